// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear systolic array of affine-gap alignment PEs: query load,
// anti-diagonal reference streaming, flush and best-cell tracking. Optional abort via SW_CTRL_ABORT_EN.
module sw_array_ctrl #(
  parameter int NUM_PE  = 64,
  parameter int MAX_LEN = 1024,
  parameter int WIDTH   = 14,
  parameter int QW      = 7,
  parameter int RW      = 11
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [QW-1:0]           i_q_len,
  input  logic [RW-1:0]           i_r_len,
  input  logic                    i_q_valid,
  output logic                    o_q_ready,
  input  logic [1:0]              i_q_base,
  output logic                    o_r_req,
  output logic [RW-2:0]           o_r_addr,
  input  logic [1:0]              i_r_base,
  output logic                    o_clear,
  output logic                    o_q_load_en,
  output logic [QW-2:0]           o_q_load_idx,
  output logic [1:0]              o_q_load_base,
  output logic                    o_shift_en,
  output logic [1:0]              o_ref_base,
  output logic                    o_ref_valid,
  input  logic                    i_max_valid,
  input  logic signed [WIDTH-1:0] i_max_score,
  input  logic [QW-2:0]           i_max_pe,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [WIDTH-1:0]        o_best_score,
  output logic [QW-2:0]           o_best_row,
  output logic [RW-2:0]           o_best_col
`ifdef SW_CTRL_ABORT_EN
  ,
  input  logic                    i_abort,
  output logic                    o_abort_ack
`endif
);

  localparam int SW = RW + 1;

  typedef enum logic [2:0] {IDLE, LOAD_Q, RUN, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [QW-1:0]            q_len_r;
  logic [RW-1:0]            r_len_r;
  logic [QW-1:0]            q_cnt;
  logic [SW-1:0]            step;
  logic [SW-1:0]            beat;
  logic [SW-1:0]            beat_nxt;
  logic [SW-1:0]            total;
  logic [SW-1:0]            r_ext;
  logic                     clear_q;
  logic                     shift_q;
  logic                     ref_valid_q;
  logic                     err_q;
  logic signed [WIDTH-1:0]  best_score;
  logic [QW-2:0]            best_row;
  logic [RW-2:0]            best_col;
  logic signed [SW:0]       col;
  logic                     legal;
  logic                     abort;
  logic                     q_beat;
  logic                     run_step;
  logic                     beat_inc;
  logic                     upd;

  assign legal = (i_q_len != '0) && (i_q_len <= QW'(NUM_PE)) &&
                 (i_r_len != '0) && (i_r_len <= RW'(MAX_LEN));

`ifdef SW_CTRL_ABORT_EN
  assign abort = i_abort && (state != IDLE);
`else
  assign abort = 1'b0;
`endif

  assign r_ext    = SW'(r_len_r);
  assign total    = SW'(r_len_r) + SW'(q_len_r) - SW'(1);
  assign q_beat   = (state == LOAD_Q) && i_q_valid;
  assign run_step = (state == RUN) && !abort;

  // Beats are capped at the job's diagonal count so stray extras cannot wrap the counter.
  assign beat_inc = i_max_valid && ((state == RUN) || (state == DRAIN)) && (beat < total);
  assign beat_nxt = beat + SW'(beat_inc);

  assign col = $signed({1'b0, beat}) - $signed({{(SW + 2 - QW){1'b0}}, i_max_pe});
  assign upd = ({1'b0, i_max_pe} < q_len_r) && (col >= 0) &&
               (col < $signed({{(SW + 1 - RW){1'b0}}, r_len_r})) &&
               (i_max_score > best_score);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    o_q_ready     = 1'b0;
    o_q_load_en   = 1'b0;
    o_q_load_idx  = '0;
    o_q_load_base = '0;
    o_r_req       = 1'b0;
    o_r_addr      = '0;
    o_busy        = (state != IDLE);
    o_done        = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = legal ? LOAD_Q : DONE;
      end
      LOAD_Q: begin
        o_q_ready = 1'b1;
        if (q_beat) begin
          o_q_load_en   = 1'b1;
          o_q_load_idx  = q_cnt[QW-2:0];
          o_q_load_base = i_q_base;
          if (q_cnt == q_len_r - QW'(1)) state_nxt = RUN;
        end
      end
      RUN: begin
        if (step < r_ext) begin
          o_r_req  = 1'b1;
          o_r_addr = step[RW-2:0];
        end
        if (step == total - SW'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (beat_nxt == total) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_len_r     <= '0;
      r_len_r     <= '0;
      q_cnt       <= '0;
      step        <= '0;
      beat        <= '0;
      clear_q     <= 1'b0;
      shift_q     <= 1'b0;
      ref_valid_q <= 1'b0;
      err_q       <= 1'b0;
      best_score  <= '0;
      best_row    <= '0;
      best_col    <= '0;
    end else begin
      clear_q     <= 1'b0;
      // The shift for a step lands one cycle after its read, aligned with i_r_base.
      shift_q     <= run_step;
      ref_valid_q <= run_step && (step < r_ext);
      if ((state == IDLE) && i_start) begin
        q_len_r    <= i_q_len;
        r_len_r    <= i_r_len;
        q_cnt      <= '0;
        step       <= '0;
        beat       <= '0;
        clear_q    <= 1'b1;
        err_q      <= !legal;
        best_score <= '0;
        best_row   <= '0;
        best_col   <= '0;
      end
      if (q_beat) q_cnt <= q_cnt + QW'(1);
      if (state == RUN) step <= step + SW'(1);
      if (beat_inc) begin
        beat <= beat_nxt;
        if (upd) begin
          best_score <= i_max_score;
          best_row   <= i_max_pe;
          best_col   <= col[RW-2:0];
        end
      end
    end
  end

`ifdef SW_CTRL_ABORT_EN
  logic abort_ack_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      abort_ack_q <= 1'b0;
    end else begin
      abort_ack_q <= abort;
    end
  end

  assign o_abort_ack = abort_ack_q;
`endif

  assign o_clear      = clear_q;
  assign o_shift_en   = shift_q;
  assign o_ref_valid  = ref_valid_q;
  assign o_ref_base   = ref_valid_q ? i_r_base : 2'b00;
  assign o_err        = err_q;
  assign o_best_score = best_score;
  assign o_best_row   = best_row;
  assign o_best_col   = best_col;

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Scoreboard bench for sw_array_ctrl: random jobs against a reference model of the
// wavefront sequencing and best-cell rules; abort scenario when SW_CTRL_ABORT_EN is defined.
module tb_sw_array_ctrl;
  localparam int NUM_PE  = 64;
  localparam int MAX_LEN = 1024;
  localparam int WIDTH   = 14;
  localparam int QW      = 7;
  localparam int RW      = 11;
  localparam int PW      = QW - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    i_start;
  logic [QW-1:0]           i_q_len;
  logic [RW-1:0]           i_r_len;
  logic                    i_q_valid;
  logic                    o_q_ready;
  logic [1:0]              i_q_base;
  logic                    o_r_req;
  logic [RW-2:0]           o_r_addr;
  logic [1:0]              i_r_base;
  logic                    o_clear;
  logic                    o_q_load_en;
  logic [QW-2:0]           o_q_load_idx;
  logic [1:0]              o_q_load_base;
  logic                    o_shift_en;
  logic [1:0]              o_ref_base;
  logic                    o_ref_valid;
  logic                    i_max_valid;
  logic signed [WIDTH-1:0] i_max_score;
  logic [QW-2:0]           i_max_pe;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_err;
  logic [WIDTH-1:0]        o_best_score;
  logic [QW-2:0]           o_best_row;
  logic [RW-2:0]           o_best_col;
`ifdef SW_CTRL_ABORT_EN
  logic                    i_abort;
  logic                    o_abort_ack;
`endif

  always #5 clk = ~clk;

  sw_array_ctrl #(.NUM_PE(NUM_PE), .MAX_LEN(MAX_LEN), .WIDTH(WIDTH), .QW(QW), .RW(RW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_q_len(i_q_len), .i_r_len(i_r_len),
    .i_q_valid(i_q_valid), .o_q_ready(o_q_ready), .i_q_base(i_q_base),
    .o_r_req(o_r_req), .o_r_addr(o_r_addr), .i_r_base(i_r_base), .o_clear(o_clear),
    .o_q_load_en(o_q_load_en), .o_q_load_idx(o_q_load_idx), .o_q_load_base(o_q_load_base),
    .o_shift_en(o_shift_en), .o_ref_base(o_ref_base), .o_ref_valid(o_ref_valid),
    .i_max_valid(i_max_valid), .i_max_score(i_max_score), .i_max_pe(i_max_pe),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_best_score(o_best_score),
    .o_best_row(o_best_row), .o_best_col(o_best_col)
`ifdef SW_CTRL_ABORT_EN
    , .i_abort(i_abort), .o_abort_ack(o_abort_ack)
`endif
  );

  typedef struct {int score; int pe;} beat_t;
  typedef struct {bit err; bit abort; int score; int row; int col; int nshift; int nvalid;} exp_t;

  int     errors = 0;
  int     checks = 0;
  beat_t  beats[$];
  int     beat_idx = 0;
  exp_t   exp_q[$];
  int     qexp[$];
  logic [1:0] ref_mem [MAX_LEN];
  int     shift_cnt = 0, valid_cnt = 0, req_cnt = 0, load_cnt = 0, evt_cnt = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred where none was expected", name);
  endtask

  // Reference memory: data returns one cycle after the read strobe.
  initial begin
    logic          p;
    logic [RW-2:0] a;
    i_r_base = 2'b00;
    forever begin
      @(negedge clk);
      p = o_r_req;
      a = o_r_addr;
      @(posedge clk);
      #1;
      i_r_base = p ? ref_mem[a] : 2'($urandom);
    end
  end

  // Array stand-in: beat k may appear only after at least k+1 shifts have been seen.
  initial begin
    i_max_valid = 1'b0;
    i_max_score = '0;
    i_max_pe    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (beat_idx < beats.size() && beat_idx < shift_cnt && $urandom_range(3) != 0) begin
        i_max_valid = 1'b1;
        i_max_score = WIDTH'(beats[beat_idx].score);
        i_max_pe    = PW'(beats[beat_idx].pe);
        beat_idx++;
      end else begin
        i_max_valid = 1'b0;
        i_max_score = WIDTH'($urandom);
        i_max_pe    = PW'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_q_load_en) begin
        if (qexp.size() == 0) fail_now("unexpected_q_load");
        else begin
          chk("q_load_base", int'(o_q_load_base), qexp.pop_front());
          chk("q_load_idx", int'(o_q_load_idx), load_cnt);
        end
        load_cnt++;
      end
      if (o_r_req) begin
        chk("r_addr", int'(o_r_addr), req_cnt);
        req_cnt++;
      end
      if (o_shift_en) begin
        if (o_ref_valid) begin
          if (valid_cnt < MAX_LEN) chk("ref_base", int'(o_ref_base), int'(ref_mem[valid_cnt]));
          valid_cnt++;
        end else begin
          chk("ref_base_flush", int'(o_ref_base), 0);
        end
        shift_cnt++;
      end
      if (o_done) begin
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          e = exp_q.pop_front();
          if (e.abort) fail_now("done_after_abort");
          chk("err", int'(o_err), int'(e.err));
          chk("best_score", int'($signed(o_best_score)), e.score);
          chk("best_row", int'(o_best_row), e.row);
          chk("best_col", int'(o_best_col), e.col);
          chk("shift_count", shift_cnt, e.nshift);
          chk("ref_valid_count", valid_cnt, e.nvalid);
          chk("r_req_count", req_cnt, e.nvalid);
        end
        shift_cnt = 0; valid_cnt = 0; req_cnt = 0; load_cnt = 0;
        evt_cnt++;
      end
`ifdef SW_CTRL_ABORT_EN
      if (o_abort_ack) begin
        if (exp_q.size() == 0) fail_now("unexpected_abort_ack");
        else begin
          e = exp_q.pop_front();
          chk("abort_ack_expected", 1, int'(e.abort));
        end
        shift_cnt = 0; valid_cnt = 0; req_cnt = 0; load_cnt = 0;
        evt_cnt++;
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: random beats, 1: diagonal ACGT case, 2: tie/out-of-range, 3: all negative
  task automatic run_job(input int q, input int r, input int mode, input bit inject_start,
                         input bit do_abort);
    exp_t  e;
    beat_t bt;
    bit    legal;
    int    prev, n, tot, c;
    beat_t blist[$];
    legal = (q >= 1 && q <= NUM_PE && r >= 1 && r <= MAX_LEN);
    tot   = q + r - 1;
    for (int i = 0; i < MAX_LEN; i++) ref_mem[i] = (mode == 1) ? 2'(i) : 2'($urandom);
    if (legal) begin
      for (int b = 0; b < tot; b++) begin
        bt.pe = $urandom_range(q - 1);
        if ($urandom_range(7) == 0) bt.pe = $urandom_range(NUM_PE - 1);
        bt.score = int'($urandom_range(340)) - 40;
        if (mode == 1) begin
          bt.pe = (b % 2 == 0) ? b / 2 : 0;
          bt.score = (b == 0) ? 3 : (b == 2) ? 7 : (b == 4) ? 11 : (b == 6) ? 14 : 1;
        end else if (mode == 2) begin
          bt.pe = (b == 3) ? 1 : (b == 5) ? 2 : 0;
          bt.score = (b == 3 || b == 5) ? 20 : (b == 6) ? 99 : 0;
        end else if (mode == 3) begin
          bt.score = -int'($urandom_range(1, 100));
        end
        blist.push_back(bt);
      end
    end
    e = '{err: !legal, abort: do_abort, score: 0, row: 0, col: 0,
          nshift: legal ? tot : 0, nvalid: legal ? r : 0};
    foreach (blist[b]) begin
      c = b - blist[b].pe;
      if (blist[b].pe < q && c >= 0 && c < r && blist[b].score > e.score) begin
        e.score = blist[b].score;
        e.row = blist[b].pe;
        e.col = c;
      end
    end
    exp_q.push_back(e);
    prev = evt_cnt;
    beats = blist;
    beat_idx = 0;
    i_q_len = QW'(q);
    i_r_len = RW'(r);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("clear_pulse", int'(o_clear), 1);
    if (!legal) begin
      chk("reject_done", int'(o_done), 1);
      chk("reject_err", int'(o_err), 1);
      chk("reject_no_ready", int'(o_q_ready), 0);
    end else begin
      chk("ready_after_start", int'(o_q_ready), 1);
      for (int i = 0; i < q; i++) begin
        while ($urandom_range(3) == 0) begin
          i_q_valid = 1'b0;
          tick();
        end
        i_q_valid = 1'b1;
        i_q_base  = (mode == 1) ? 2'(i) : 2'($urandom);
        qexp.push_back(int'(i_q_base));
        tick();
      end
      i_q_valid = 1'b0;
      chk("shift_not_at_run_entry", int'(o_shift_en), 0);
      tick();
      chk("first_shift", int'(o_shift_en), 1);
      if (inject_start) begin
        repeat (4) tick();
        i_q_len = QW'(1);
        i_r_len = RW'(1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
      end
`ifdef SW_CTRL_ABORT_EN
      if (do_abort) begin
        n = 0;
        while (!(o_r_req && o_r_addr == 10) && n < 200) begin
          tick();
          n++;
        end
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_idle", int'(o_busy), 0);
        chk("abort_ack_pulse", int'(o_abort_ack), 1);
        beats.delete();
        repeat (3) tick();
      end
`endif
    end
    n = 0;
    while (evt_cnt == prev && n < 6000) begin
      tick();
      n++;
    end
    if (evt_cnt == prev) fail_now("job_timeout");
    repeat ($urandom_range(1, 3)) tick();
  endtask

  initial begin
    i_start = 1'b0; i_q_len = '0; i_r_len = '0; i_q_valid = 1'b0; i_q_base = '0;
`ifdef SW_CTRL_ABORT_EN
    i_abort = 1'b0;
`endif
    #23;
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_done", int'(o_done), 0);
    chk("reset_err", int'(o_err), 0);
    chk("reset_best_score", int'(o_best_score), 0);
    chk("reset_best_row", int'(o_best_row), 0);
    chk("reset_best_col", int'(o_best_col), 0);
    chk("reset_ready", int'(o_q_ready), 0);
    chk("reset_shift", int'(o_shift_en), 0);
    chk("reset_req", int'(o_r_req), 0);
    chk("reset_clear", int'(o_clear), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_job(4, 4, 1, 0, 0);
    run_job(0, 4, 0, 0, 0);
    run_job(4, MAX_LEN + 1, 0, 0, 0);
    run_job(NUM_PE + 1, 10, 0, 0, 0);
    run_job(4, 4, 2, 0, 0);
    run_job(1, 1, 0, 0, 0);
    run_job(NUM_PE, MAX_LEN, 0, 0, 0);
    run_job(6, 20, 3, 1, 0);
    for (int k = 0; k < 6; k++) run_job($urandom_range(1, NUM_PE), $urandom_range(1, 80), 0, 0, 0);
`ifdef SW_CTRL_ABORT_EN
    run_job(8, 32, 0, 0, 1);
    run_job(5, 12, 0, 0, 0);
`endif
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("query_queue_empty", qexp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sw_array_ctrl.md
# sw_array_ctrl

Sequencer for a linear systolic array of `NUM_PE` affine-gap alignment PEs: loads a query segment into the PEs, streams reference bases from a base memory on an anti-diagonal wavefront, and flushes the array. It also tracks the best cell score and reports its (row, col). It sits between the host start/load interface and the PE array, one alignment job at a time.

## Interface
- `NUM_PE`, 64: PEs in the array; max query length.
- `MAX_LEN`, 1024: max reference length.
- `WIDTH`, 14: signed score width.
- `QW`, 7: query length / PE index width (clog2(NUM_PE)+1).
- `RW`, 11: reference length / column width (clog2(MAX_LEN)+1).
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: job start; sampled in IDLE only.
- `i_q_len` in QW: query length, sampled with `i_start`.
- `i_r_len` in RW: reference length, sampled with `i_start`.
- `i_q_valid` / `o_q_ready` in/out 1: query base handshake.
- `i_q_base` in 2: query base (A=0, C=1, G=2, T=3).
- `o_r_req` out 1: reference memory read strobe.
- `o_r_addr` out RW-1: reference address.
- `i_r_base` in 2: read data, valid exactly 1 cycle after `o_r_req`.
- `o_clear` out 1: 1-cycle pulse; clears array boundary registers.
- `o_q_load_en` out 1: write `o_q_load_base` into PE `o_q_load_idx`.
- `o_q_load_idx` out QW-1: target PE index.
- `o_q_load_base` out 2: base to load.
- `o_shift_en` out 1: advance the wavefront one step.
- `o_ref_base` out 2: base entering PE 0.
- `o_ref_valid` out 1: `o_ref_base` is real; 0 during flush.
- `i_max_valid` in 1: one beat per processed anti-diagonal.
- `i_max_score` in WIDTH signed: best score on that anti-diagonal.
- `i_max_pe` in QW-1: PE index holding it.
- `o_busy` out 1: not IDLE.
- `o_done` out 1: 1-cycle completion pulse.
- `o_err` out 1: job rejected; valid with `o_done`.
- `o_best_score` out WIDTH: best score; held until next accepted start.
- `o_best_row` out QW-1: best score row.
- `o_best_col` out RW-1: best score column.

## Operation
- States: IDLE, LOAD_Q, RUN, DRAIN, DONE.
- **IDLE:**
  - On `i_start`, latch the lengths and pulse `o_clear`.
  - Clear best to score 0, row 0, col 0.
  - Go to LOAD_Q if lengths are legal, else to DONE with `o_err`=1.
  - Legal means 1 ≤ q_len ≤ NUM_PE and 1 ≤ r_len ≤ MAX_LEN.
- **LOAD_Q:**
  - `o_q_ready`=1.
  - Each `i_q_valid`&`o_q_ready` beat asserts `o_q_load_en` with idx = beat count (0..q_len-1).
  - After the beat with idx q_len-1, go to RUN.
- **RUN:** step counter s = 0..r_len+q_len-2.
  - For s < r_len: `o_r_req`=1, `o_r_addr`=s.
  - For s ≥ r_len: no request.
  - One cycle later, `o_shift_en`=1 and `o_ref_valid`=(s<r_len) with `o_ref_base`=`i_r_base` (0 when invalid).
  - After issuing the last step, go to DRAIN.
- **DRAIN:**
  - Wait until beat counter b reaches r_len+q_len-1 `i_max_valid` beats.
  - b counts in RUN and DRAIN.
  - Then go to DONE.
- **Best tracking:** on each `i_max_valid` beat b with pe=`i_max_pe`:
  - col = b − pe, compared signed.
  - Update only if pe < q_len, 0 ≤ col < r_len, and `i_max_score` > best (strict signed).
  - Ties keep the earlier beat; best never drops below 0.
- **DONE:** pulse `o_done` for one cycle, then go to IDLE. Results and `o_err` are held until the next accepted start.
- `i_start` outside IDLE is ignored.
- `i_max_valid` outside RUN/DRAIN is ignored.

## Timing
- Reset values: state IDLE; every output 0. `o_best_*` are 0 and `o_err` is 0.
- Start → first `o_q_ready`: 1 cycle. `o_clear` is asserted in the cycle after `i_start`.
- Query load: q_len cycles minimum; back-pressure free, `o_q_ready` held high throughout.
- First `o_shift_en`: 2 cycles after the last query beat (RUN entry + memory latency).
- `o_shift_en` is contiguous for r_len+q_len-1 cycles.
- `o_done` fires the cycle after the final beat is counted, or 1 cycle after `i_start` for a rejected job.
- Async reset mid-job returns immediately to IDLE with no `o_done`.

## Configuration
- `SW_CTRL_ABORT_EN`:
  - When defined, adds input `i_abort` and output `o_abort_ack`.
  - `i_abort` in any non-IDLE state forces IDLE next cycle and pulses `o_abort_ack` for 1 cycle.
  - No `o_done` follows an abort; `o_best_*` hold their partial values.
  - `i_abort` in IDLE is ignored.
  - Undefined: both ports are absent and jobs always run to DONE.

## Test plan
- q_len=4 "ACGT", r_len=4 "ACGT", array model returns diagonal scores 3,7,11,14 at pe=0..3 on beats 0,2,4,6 → exactly 7 shifts; o_best_score=14, row=3, col=3, o_done one pulse, o_err=0.
- q_len=0 or r_len=MAX_LEN+1 → o_done the cycle after i_start, o_err=1, no o_q_ready/o_r_req/o_shift_en.
- Two beats both scoring 20 (beat 3 pe 1, beat 5 pe 2) → best row=1, col=2 (tie keeps first); a beat with col=b−pe ≥ r_len scoring 99 is ignored.
- q_len=NUM_PE, r_len=MAX_LEN → o_r_addr sweeps 0..1023 once; o_ref_valid low for the last 63 shifts; o_shift_en count 1087.
- All reported scores negative → o_best_score=0, row=0, col=0; i_start pulsed during RUN has no effect.
- With SW_CTRL_ABORT_EN: i_abort at RUN step 10 → IDLE next cycle, o_abort_ack pulse, no o_done; a new job then completes normally.
